// File: rtl/viterbi_ctrl.sv
// Frame sequencer for a rate-1/2 Viterbi datapath: forward ACS pass, survivor traceback,
// and in-order re-emission of the reversed traceback bits through a valid/ready port.
module viterbi_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        rx_pair,
    output logic [1:0]        bmc_pair,
    output logic              acs_en,
    output logic              acs_init,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              tb_en,
    output logic              tb_start,
    input  logic              tb_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_TB     = 3'd2,
        S_TB_CAP = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   LP_LEN  = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] LP_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_sym_cnt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [1:0]        r_bmc_pair;
    logic              r_acs_en;
    logic              r_acs_init;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_tb_en;
    logic              r_tb_start;
    logic              r_out_valid;
    logic              r_out_bit;
    logic              r_frame_done;
    logic              r_cap_vld;
    logic [ADDR_W-1:0] r_cap_addr;
    logic              r_buf [0:(1 << ADDR_W) - 1];

    logic              w_in_ready;
    logic              w_accept;
    logic [ADDR_W-1:0] w_rd_next;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_FWD) && (r_sym_cnt < LP_LEN));
    assign w_accept   = in_valid & w_in_ready;
    assign w_rd_next  = r_rd_cnt + LP_ONE;

    // Frame sequencer: forward pass, countdown traceback, capture slot and output drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sym_cnt    <= '0;
            r_rd_cnt     <= '0;
            r_bmc_pair   <= 2'b00;
            r_acs_en     <= 1'b0;
            r_acs_init   <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_tb_en      <= 1'b0;
            r_tb_start   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_bit    <= 1'b0;
            r_frame_done <= 1'b0;
            r_cap_vld    <= 1'b0;
            r_cap_addr   <= '0;
        end else begin
            r_acs_en     <= 1'b0;
            r_acs_init   <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_frame_done <= 1'b0;
            // Traceback bits trail their address by one cycle.
            r_cap_vld    <= r_tb_en;
            r_cap_addr   <= r_mem_addr;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bmc_pair <= rx_pair;
                        r_acs_en   <= 1'b1;
                        r_acs_init <= 1'b1;
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= LP_ZERO;
                        r_sym_cnt  <= (ADDR_W + 1)'(1);
                        r_state    <= S_FWD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FWD: begin
                    if (r_sym_cnt == LP_LEN) begin
                        r_tb_en    <= 1'b1;
                        r_tb_start <= 1'b1;
                        r_mem_addr <= LP_LAST;
                        r_state    <= S_TB;
                    end else if (w_accept) begin
                        r_bmc_pair <= rx_pair;
                        r_acs_en   <= 1'b1;
                        r_acs_init <= (r_sym_cnt == (ADDR_W + 1)'(0));
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= r_sym_cnt[ADDR_W-1:0];
                        r_sym_cnt  <= r_sym_cnt + (ADDR_W + 1)'(1);
                    end else begin
                        r_state <= S_FWD;
                    end
                end
                S_TB: begin
                    r_tb_start <= 1'b0;
                    if (r_mem_addr == LP_ZERO) begin
                        r_tb_en <= 1'b0;
                        r_state <= S_TB_CAP;
                    end else begin
                        r_mem_addr <= r_mem_addr - LP_ONE;
                    end
                end
                S_TB_CAP: begin
                    // The bit landing now belongs to address 0, so present it directly.
                    r_out_valid <= 1'b1;
                    r_out_bit   <= tb_bit;
                    r_rd_cnt    <= LP_ZERO;
                    r_state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_cnt == LP_LAST) begin
                            r_out_valid  <= 1'b0;
                            r_out_bit    <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_rd_cnt     <= LP_ZERO;
                            r_sym_cnt    <= '0;
                            r_mem_addr   <= LP_ZERO;
                            r_state      <= S_IDLE;
                        end else begin
                            r_rd_cnt  <= w_rd_next;
                            r_out_bit <= r_buf[w_rd_next];
                        end
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tb_en     <= 1'b0;
                    r_tb_start  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_sym_cnt   <= '0;
                    r_rd_cnt    <= '0;
                end
            endcase
        end
    end

    // Frame buffer: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (r_cap_vld) begin
            r_buf[r_cap_addr] <= tb_bit;
        end
    end

    assign in_ready   = w_in_ready;
    assign bmc_pair   = r_bmc_pair;
    assign acs_en     = r_acs_en;
    assign acs_init   = r_acs_init;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign tb_en      = r_tb_en;
    assign tb_start   = r_tb_start;
    assign out_valid  = r_out_valid;
    assign out_bit    = r_out_bit;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl: directed table frame, bubbles, backpressure,
// mid-traceback reset and randomized frames against a frame-level scoreboard.
module tb_viterbi_ctrl;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    rx_pair;
    logic [1:0]    bmc_pair;
    logic          acs_en, acs_init, mem_wr;
    logic [AW-1:0] mem_addr;
    logic          tb_en, tb_start, tb_bit;
    logic          out_valid, out_ready, out_bit;
    logic          busy, frame_done;

    always #5 clk = ~clk;

    viterbi_ctrl #(.FRAME_LEN(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rx_pair(rx_pair),
        .bmc_pair(bmc_pair), .acs_en(acs_en), .acs_init(acs_init), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .tb_en(tb_en), .tb_start(tb_start), .tb_bit(tb_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        logic [1:0]    rx;
        logic [1:0]    exp_bmc;
        logic [AW-1:0] exp_addr;
        logic          exp_init;
        logic          exp_out;
    } vec_t;

    typedef struct {
        logic [1:0]    bmc;
        logic [AW-1:0] addr;
        logic          init;
    } fwd_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    fwd_t          fwd_q [$];
    logic [AW-1:0] tb_q  [$];
    logic          tbs_q [$];
    logic          out_q [$];
    int            last_acc, first_ov, fd_cnt, ov_cnt, side_bad;
    logic [1:0]    last_bmc;
    logic          stall_pend, stall_bit;

    logic          pat       [N];
    logic [1:0]    pairs     [N];
    int            gap       [N];
    int            stall_left[N];
    logic [1:0]    exp_bmc   [N];
    logic [AW-1:0] exp_addr  [N];
    logic          exp_init  [N];
    logic          exp_out   [N];
    vec_t          vt        [N];

    logic          en_s;
    logic [AW-1:0] a_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic parity_of(input int v);
        logic [AW-1:0] a;
        a = AW'(v);
        return ^a;
    endfunction

    task automatic clear_mon();
        fwd_q.delete(); tb_q.delete(); tbs_q.delete(); out_q.delete();
        last_acc = -1; first_ov = -1; fd_cnt = 0; ov_cnt = 0; side_bad = 0;
    endtask

    // Traceback unit stand-in: returns pat[addr] one cycle after each tb_en cycle.
    initial begin
        tb_bit = 1'b0;
        forever begin
            @(negedge clk);
            en_s = tb_en;
            a_s  = mem_addr;
            @(posedge clk);
            #1;
            tb_bit = en_s ? pat[a_s] : 1'b0;
        end
    end

    // Monitor: records forward writes, traceback steps and handshakes at the falling edge.
    initial begin
        stall_pend = 1'b0;
        last_bmc   = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                stall_pend = 1'b0;
                last_bmc   = 2'b00;
            end else begin
                if (acs_en) fwd_q.push_back('{bmc_pair, mem_addr, acs_init});
                if ((mem_wr !== acs_en) || (acs_init && !acs_en) || (tb_start && !tb_en)) side_bad++;
                if (!acs_en && (bmc_pair !== last_bmc)) side_bad++;
                last_bmc = bmc_pair;
                if (tb_en) begin
                    tb_q.push_back(mem_addr);
                    tbs_q.push_back(tb_start);
                end
                if (in_valid && in_ready) last_acc = cyc;
                if (out_valid) begin
                    ov_cnt++;
                    if (first_ov < 0) first_ov = cyc;
                end
                if (stall_pend) begin
                    check("stall_valid_held", out_valid, 1);
                    check("stall_bit_held", out_bit, stall_bit);
                end
                stall_pend = out_valid && !out_ready;
                stall_bit  = out_bit;
                if (out_valid && out_ready) out_q.push_back(out_bit);
                if (frame_done) fd_cnt++;
            end
        end
    end

    task automatic feed_pairs();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b0;
            repeat (gap[i]) step();
            check("in_ready_before_accept", in_ready, 1);
            in_valid = 1'b1;
            rx_pair  = pairs[i];
            step();
        end
    endtask

    task automatic run_frame(input bit rand_ready);
        int hs;
        int budget;
        clear_mon();
        feed_pairs();
        rx_pair = ~pairs[N-1];
        check("in_ready_low_after_last", in_ready, 0);
        check("busy_in_frame", busy, 1);
        repeat (N) step();
        in_valid = 1'b0;
        hs = 0;
        budget = 0;
        while (hs < N && budget < 400) begin
            if (out_valid) begin
                if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
                else if (stall_left[hs] > 0) begin
                    out_ready = 1'b0;
                    stall_left[hs]--;
                end else out_ready = 1'b1;
                if (out_ready) hs++;
            end else begin
                out_ready = 1'b0;
            end
            step();
            budget++;
        end
        check("drain_within_budget", hs, N);
        out_ready = 1'b0;
        check("frame_done_after_last", frame_done, 1);
        check("out_valid_low_after_last", out_valid, 0);
        step();
        check("frame_done_single", frame_done, 0);
        check("in_ready_idle", in_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    task automatic compare_frame();
        check("fwd_count", fwd_q.size(), N);
        for (int i = 0; i < N && i < int'(fwd_q.size()); i++) begin
            check("bmc_pair", fwd_q[i].bmc, exp_bmc[i]);
            check("mem_addr_fwd", fwd_q[i].addr, exp_addr[i]);
            check("acs_init", fwd_q[i].init, exp_init[i]);
        end
        check("tb_count", tb_q.size(), N);
        for (int i = 0; i < N && i < int'(tb_q.size()); i++) begin
            check("mem_addr_tb", tb_q[i], N - 1 - i);
            check("tb_start", tbs_q[i], (i == 0) ? 1 : 0);
        end
        check("out_count", out_q.size(), N);
        for (int i = 0; i < N && i < int'(out_q.size()); i++)
            check("out_bit", out_q[i], exp_out[i]);
        check("latency", first_ov - last_acc, N + 3);
        check("frame_done_pulses", fd_cnt, 1);
        check("side_rules", side_bad, 0);
    endtask

    // Frame-level reference: pair i written at address i, output bit i = traceback value at i.
    task automatic random_frame_setup(input bit with_gaps);
        for (int i = 0; i < N; i++) begin
            pairs[i]      = 2'($urandom_range(0, 3));
            pat[i]        = 1'($urandom_range(0, 1));
            gap[i]        = with_gaps ? $urandom_range(0, 2) : 0;
            stall_left[i] = 0;
            exp_bmc[i]    = pairs[i];
            exp_addr[i]   = AW'(i);
            exp_init[i]   = (i == 0);
            exp_out[i]    = pat[i];
        end
    endtask

    initial begin
        int b;
        vt[0] = '{2'b11, 2'b11, 3'd0, 1'b1, 1'b0};
        vt[1] = '{2'b10, 2'b10, 3'd1, 1'b0, 1'b1};
        vt[2] = '{2'b00, 2'b00, 3'd2, 1'b0, 1'b1};
        vt[3] = '{2'b01, 2'b01, 3'd3, 1'b0, 1'b0};
        vt[4] = '{2'b11, 2'b11, 3'd4, 1'b0, 1'b1};
        vt[5] = '{2'b11, 2'b11, 3'd5, 1'b0, 1'b0};
        vt[6] = '{2'b00, 2'b00, 3'd6, 1'b0, 1'b0};
        vt[7] = '{2'b10, 2'b10, 3'd7, 1'b0, 1'b1};

        rst = 1'b0; in_valid = 1'b0; rx_pair = 2'b00; out_ready = 1'b0;
        for (int i = 0; i < N; i++) pat[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acs_en", acs_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        #3 rst = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // Directed back-to-back frame with parity traceback pattern.
        for (int i = 0; i < N; i++) begin
            pairs[i] = vt[i].rx; gap[i] = 0; stall_left[i] = 0;
            pat[i] = parity_of(i);
            exp_bmc[i] = vt[i].exp_bmc; exp_addr[i] = vt[i].exp_addr;
            exp_init[i] = vt[i].exp_init; exp_out[i] = vt[i].exp_out;
        end
        run_frame(1'b0);
        compare_frame();

        // Input bubbles: two idle cycles between pairs.
        random_frame_setup(1'b0);
        for (int i = 1; i < N; i++) gap[i] = 2;
        run_frame(1'b0);
        compare_frame();

        // Output backpressure on bits 2 and 7.
        random_frame_setup(1'b0);
        stall_left[2] = 3;
        stall_left[7] = 3;
        run_frame(1'b0);
        compare_frame();

        // Reset during traceback after four steps.
        random_frame_setup(1'b0);
        clear_mon();
        feed_pairs();
        in_valid = 1'b0;
        b = 0;
        while (tb_q.size() < 4 && b < 50) begin
            step();
            b++;
        end
        check("tb_steps_before_reset", tb_q.size(), 4);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tb_en", tb_en, 0);
        check("mid_rst_tb_start", tb_start, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_bmc_pair", bmc_pair, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        step();
        clear_mon();
        check("post_mid_rst_in_ready", in_ready, 1);
        repeat (30) step();
        check("no_output_after_reset", ov_cnt, 0);
        check("idle_after_reset", busy, 0);
        random_frame_setup(1'b0);
        run_frame(1'b0);
        compare_frame();

        // Randomized frames with bubbles and random sink readiness.
        for (int f = 0; f < 6; f++) begin
            random_frame_setup(1'b1);
            run_frame(1'b1);
            compare_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
Sequencer for one frame of the rate-1/2 Viterbi decoder datapath. It accepts received bit pairs and registers each pair onto the shared branch-metric compute inputs. It drives the ACS enable/init and survivor-memory write address, then runs traceback over the stored frame. Traceback bits arrive in reverse order; the block re-orders them in an internal frame buffer and streams them out with a valid/ready handshake.

Parameters:
FRAME_LEN, 8, trellis steps (received pairs) per frame; legal range 2..256
ADDR_W, 3, survivor-memory / frame-buffer address width; 2**ADDR_W >= FRAME_LEN

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  rx_pair valid
in_ready  out  1  controller can accept a pair
rx_pair  in  2  received code bits
bmc_pair  out  2  registered pair driven to branch-metric compute instances
acs_en  out  1  ACS update this cycle
acs_init  out  1  clear path metrics; qualifies first step of frame
mem_wr  out  1  survivor-memory write strobe
mem_addr  out  ADDR_W  survivor-memory address (write in forward pass, read in traceback)
tb_en  out  1  traceback step this cycle
tb_start  out  1  first traceback step; traceback selects min-metric state
tb_bit  in  1  decoded bit, valid exactly 1 cycle after each tb_en cycle
out_valid  out  1  out_bit valid
out_ready  in  1  sink accepts out_bit
out_bit  out  1  decoded bit, frame order
busy  out  1  state != IDLE
frame_done  out  1  1-cycle pulse on handshake of last output bit

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, bmc_pair=0, acs_en=acs_init=mem_wr=tb_en=tb_start=0, mem_addr=0, out_valid=0, out_bit=0, frame_done=0, busy=0. in_ready=1, decoded from IDLE. Frame-buffer contents are don't-care. Reset mid-frame abandons the frame; no partial output follows.
- States: IDLE, FWD, TB, TB_CAP, DRAIN.
- Accept = in_valid & in_ready at a rising edge. in_ready=1 in IDLE and in FWD while sym_cnt < FRAME_LEN; otherwise 0.
- On accept with sym_cnt=k: next cycle bmc_pair=rx_pair, acs_en=1, mem_wr=1, mem_addr=k, acs_init=(k==0). sym_cnt increments. IDLE->FWD on first accept.
- No accept in a cycle: acs_en=mem_wr=acs_init=0 next cycle; bmc_pair holds. Bubbles are allowed anywhere in the forward pass; throughput is 1 pair/cycle.
- Last pair (k=FRAME_LEN-1) accepted at cycle c0: ACS/write occur in c1; FWD->TB at end of c1.
- TB lasts FRAME_LEN cycles, tb_en=1 throughout. mem_addr counts FRAME_LEN-1 down to 0. tb_start=1 in the first TB cycle only. mem_wr=0.
- tb_bit sampled 1 cycle after each tb_en cycle and stored at buf[previous mem_addr].
- TB->TB_CAP after the addr-0 step. TB_CAP lasts 1 cycle and captures the final bit, then goes to DRAIN.
- DRAIN: out_valid=1, out_bit=buf[rd_cnt], rd_cnt from 0. rd_cnt advances only on out_valid & out_ready. out_bit/out_valid stay stable while stalled.
- Handshake at rd_cnt=FRAME_LEN-1: frame_done=1 next cycle, out_valid=0, state IDLE, all counters 0.
- Latency: last accept c0 -> first out_valid at c0+FRAME_LEN+3 (c1 ACS, c2..c(N+1) TB, c(N+2) TB_CAP).
- in_valid while in_ready=0 is ignored; the source must hold it.
- Counter wrap: none. sym_cnt saturates at FRAME_LEN until IDLE. mem_addr never exceeds FRAME_LEN-1.

Test Plan:
- Reset check: assert rst mid-sim -> all outputs at reset values immediately (async); in_ready=1 after release.
- Back-to-back frame: FRAME_LEN=8, pairs 11,10,00,01,11,11,00,10 on consecutive cycles -> bmc_pair follows 1 cycle later; mem_addr 0..7 with mem_wr=1; acs_init=1 only with pair 0; in_ready=0 from cycle after 8th accept.
- Traceback ordering: bench returns tb_bit = parity(mem_addr) delayed 1 cycle -> mem_addr 7..0 during tb_en; tb_start only at addr 7; out_bit sequence 0,1,1,0,1,0,0,1; first out_valid exactly 11 cycles after last accept.
- Input bubbles: in_valid toggled 1,0,0,1,... -> acs_en pulses only after accepts; mem_addr still 0..7 contiguous; bmc_pair held during gaps.
- Output backpressure: out_ready low 3 cycles on bit 2 and on bit 7 -> out_bit stable while stalled; exactly 8 handshakes; frame_done a single pulse after the 8th; then IDLE with in_ready=1.
- Reset during TB (after 4 tb_en cycles) -> tb_en=0, out_valid never rises. A following full frame decodes correctly with acs_init on its first pair.
